// File: rtl/alu_seq_if.sv
// Operand/result bundle between the multi-cycle control unit (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [5:0]         opcode;
    logic [5:0]         func;
    logic [WIDTH-1:0]   rs_val;
    logic [WIDTH-1:0]   rt_val;
    logic [SHAMT_W-1:0] shamt;
    logic [15:0]        raw_val;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               sig_b;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (
        output start, opcode, func, rs_val, rt_val, shamt, raw_val,
        input  busy, done, result, sig_b, hi, lo
    );

    modport slave (
        input  start, opcode, func, rs_val, rt_val, shamt, raw_val,
        output busy, done, result, sig_b, hi, lo
    );
endinterface

// File: rtl/alu_seq.sv
// Registered MIPS ALU: single-cycle ops finish in one cycle; MULT/DIV family iterates
// one bit per cycle on operand magnitudes and applies the sign fix-up on the last step.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

    state_t             state;
    logic               busy_q, done_q, sig_b_q;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q;
    logic [SHAMT_W-1:0] count;

    logic [WIDTH-1:0]   acc, quo, operand_b, rs_hold;
    logic               is_div, neg_q, neg_r, div_zero;

    logic               accept, iter_op, iter_div, iter_signed;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH-1:0]   imm_sext, imm_zext, imm_upper;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_sig_b;

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   acc_nx, quo_nx, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] product, product_fix;

    // MULT 011000, MULTU 011001, DIV 011010, DIVU 011011: func[1] selects divide, func[0] unsigned.
    assign iter_op     = (bus.opcode == OP_RTYPE) && (bus.func[5:2] == 4'b0110);
    assign iter_div    = bus.func[1];
    assign iter_signed = ~bus.func[0];
    assign accept      = bus.start && (state != ITER);

    assign rs_neg = iter_signed & bus.rs_val[WIDTH-1];
    assign rt_neg = iter_signed & bus.rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

    assign imm_sext  = WIDTH'($signed(bus.raw_val));
    assign imm_zext  = WIDTH'(bus.raw_val);
    assign imm_upper = WIDTH'({bus.raw_val, {WIDTH{1'b0}}} >> 16);

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no decode path can infer a latch.
        sc_result = '0;
        sc_sig_b  = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.func)
                    F_ADD, F_ADDU: sc_result = bus.rs_val + bus.rt_val;
                    F_SUB, F_SUBU: sc_result = bus.rs_val - bus.rt_val;
                    F_AND:  sc_result = bus.rs_val & bus.rt_val;
                    F_OR:   sc_result = bus.rs_val | bus.rt_val;
                    F_XOR:  sc_result = bus.rs_val ^ bus.rt_val;
                    F_NOR:  sc_result = ~(bus.rs_val | bus.rt_val);
                    F_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(bus.rs_val) < $signed(bus.rt_val)};
                    F_SLTU: sc_result = {{(WIDTH-1){1'b0}}, bus.rs_val < bus.rt_val};
                    F_SLL:  sc_result = bus.rt_val << bus.shamt;
                    F_SRL:  sc_result = bus.rt_val >> bus.shamt;
                    F_SRA:  sc_result = $signed(bus.rt_val) >>> bus.shamt;
                    F_MFHI: sc_result = hi_q;
                    F_MFLO: sc_result = lo_q;
                    default: ;
                endcase
            end
            OP_ADDI: sc_result = bus.rs_val + imm_sext;
            OP_SLTI: sc_result = {{(WIDTH-1){1'b0}}, $signed(bus.rs_val) < $signed(imm_sext)};
            OP_ANDI: sc_result = bus.rs_val & imm_zext;
            OP_ORI:  sc_result = bus.rs_val | imm_zext;
            OP_LUI:  sc_result = imm_upper;
            OP_BEQ: begin
                sc_result = bus.rs_val - bus.rt_val;
                sc_sig_b  = (bus.rs_val == bus.rt_val);
            end
            OP_BNE: begin
                sc_result = bus.rs_val - bus.rt_val;
                sc_sig_b  = (bus.rs_val != bus.rt_val);
            end
            default: ;
        endcase
    end

    // {acc, quo} is one shift register: shift-add right for multiply, restoring shift-subtract left for divide.
    always_comb begin
        mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, operand_b} : '0);
        div_shift = {acc, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_b};
        if (is_div) begin
            acc_nx = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            acc_nx = mul_sum[WIDTH:1];
            quo_nx = {mul_sum[0], quo[WIDTH-1:1]};
        end
        product     = {acc_nx, quo_nx};
        product_fix = neg_q ? -product : product;
        if (is_div) begin
            fin_lo = div_zero ? '1 : (neg_q ? -quo_nx : quo_nx);
            fin_hi = div_zero ? rs_hold : (neg_r ? -acc_nx : acc_nx);
        end else begin
            fin_lo = product_fix[WIDTH-1:0];
            fin_hi = product_fix[2*WIDTH-1:WIDTH];
        end
    end

    // NOTE: the working registers carry no reset; they are always loaded on accept before ITER reads them.
    always_ff @(posedge clk) begin
        if (accept && iter_op) begin
            acc       <= '0;
            quo       <= rs_mag;
            operand_b <= rt_mag;
            rs_hold   <= bus.rs_val;
            is_div    <= iter_div;
            neg_q     <= rs_neg ^ rt_neg;
            neg_r     <= rs_neg;
            div_zero  <= (bus.rt_val == '0);
        end else if (state == ITER) begin
            acc <= acc_nx;
            quo <= quo_nx;
        end
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            sig_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            count    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    if (bus.start) begin
                        if (iter_op) begin
                            state  <= ITER;
                            busy_q <= 1'b1;
                            count  <= '0;
                        end else begin
                            done_q   <= 1'b1;
                            result_q <= sc_result;
                            sig_b_q  <= sc_sig_b;
                        end
                    end
                end
                ITER: begin
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state    <= FIN;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        hi_q     <= fin_hi;
                        lo_q     <= fin_lo;
                        result_q <= fin_lo;
                        sig_b_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.sig_b  = sig_b_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule
